// File: rtl/regfile_sequencer_if.sv
// Bus between the instruction sequencer and its instruction source / register file.
// Signal names mirror the sequencer's external pin names.
interface regfile_sequencer_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          input_Start;
  logic [DW-1:0] input_Instruction;
  logic [DW-1:0] input_Read_Data1;
  logic [DW-1:0] input_Read_Data2;
  logic          output_Read_Write;
  logic [AW-1:0] output_Read_Register1;
  logic [AW-1:0] output_Read_Register2;
  logic [AW-1:0] output_Write_Register;
  logic [DW-1:0] output_Write_Data;
  logic          output_Busy;
  logic          output_Done;

  modport master (
    input  input_Start, input_Instruction, input_Read_Data1, input_Read_Data2,
    output output_Read_Write, output_Read_Register1, output_Read_Register2,
    output output_Write_Register, output_Write_Data, output_Busy, output_Done
  );

  modport slave (
    output input_Start, input_Instruction, input_Read_Data1, input_Read_Data2,
    input  output_Read_Write, output_Read_Register1, output_Read_Register2,
    input  output_Write_Register, output_Write_Data, output_Busy, output_Done
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Five-state read/execute/write sequencer driving a 4x8 register file.
// Optional feature macro: REGSEQ_SUB_EN (opcode 10 = SUB when defined, NOP otherwise).
module regfile_sequencer (
  input logic                 input_Clock,
  input logic                 input_Reset,
  regfile_sequencer_if.master bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned OW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [OW-1:0] OP_ADD  = 2'b00;
  localparam logic [OW-1:0] OP_ADDI = 2'b01;
  localparam logic [OW-1:0] OP_SUB  = 2'b10;

  state_e        state_q;
  logic [OW-1:0] op_q;
  logic [1:0]    imm_q;
  logic [AW-1:0] rd_addr1_q;
  logic [AW-1:0] rd_addr2_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] result_q;
  logic          rw_q;
  logic          busy_q;
  logic          done_q;

  logic [DW-1:0] result_d;
  logic          write_en_d;

  // ALU on the registered read data; only consumed during EXEC
  always_comb begin
    result_d   = '0;
    write_en_d = 1'b1;
    case (op_q)
      OP_ADD:  result_d = DW'(bus.input_Read_Data1 + bus.input_Read_Data2);
      OP_ADDI: result_d = DW'(bus.input_Read_Data1 + {{(DW-2){imm_q[1]}}, imm_q});
      OP_SUB: begin
`ifdef REGSEQ_SUB_EN
        result_d = DW'(bus.input_Read_Data1 - bus.input_Read_Data2);
`else
        write_en_d = 1'b0;
`endif
      end
      default: result_d = bus.input_Read_Data1;
    endcase
  end

  always_ff @(posedge input_Clock) begin
    if (input_Reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      imm_q      <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      wr_addr_q  <= '0;
      result_q   <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.input_Start) begin
            op_q       <= bus.input_Instruction[7:6];
            imm_q      <= bus.input_Instruction[1:0];
            rd_addr1_q <= bus.input_Instruction[5:4];
            rd_addr2_q <= bus.input_Instruction[3:2];
            // ADDI writes back to rt; everything else to rd
            wr_addr_q  <= (bus.input_Instruction[7:6] == OP_ADDI) ?
                          bus.input_Instruction[3:2] : bus.input_Instruction[1:0];
            result_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: state_q <= S_EXEC;
        S_EXEC: begin
          result_q <= write_en_d ? result_d : '0;
          rw_q     <= write_en_d;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          rw_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.output_Read_Write     = rw_q;
  assign bus.output_Read_Register1 = rd_addr1_q;
  assign bus.output_Read_Register2 = rd_addr2_q;
  assign bus.output_Write_Register = wr_addr_q;
  assign bus.output_Write_Data     = result_q;
  assign bus.output_Busy           = busy_q;
  assign bus.output_Done           = done_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomised bench for regfile_sequencer with a behavioural register file and
// an instruction-level reference model.
module tb_regfile_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .input_Clock (clk),
    .input_Reset (rst),
    .bus         (bus)
  );

  logic [7:0] rf       [4];
  logic [7:0] ref_regs [4];
  int n_checks = 0;
  int n_fail   = 0;

  // Register file: registered read ports, write on the edge ending a write-mode cycle
  always @(posedge clk) begin
    if (bus.output_Read_Write) rf[bus.output_Write_Register] <= bus.output_Write_Data;
    bus.input_Read_Data1 <= rf[bus.output_Read_Register1];
    bus.input_Read_Data2 <= rf[bus.output_Read_Register2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction-level semantics over the reference register contents
  function automatic void predict(input logic [7:0] ins, output bit we,
                                  output logic [1:0] wa, output logic [7:0] wd);
    int a, b, imm;
    a   = int'(ref_regs[ins[5:4]]);
    b   = int'(ref_regs[ins[3:2]]);
    imm = int'(ins[1:0]);
    if (imm > 1) imm = imm - 4;
    we = 1'b1;
    wa = ins[1:0];
    wd = 8'h00;
    case (ins[7:6])
      2'd0: wd = 8'(a + b);
      2'd1: begin wa = ins[3:2]; wd = 8'(a + imm); end
      2'd2: begin
`ifdef REGSEQ_SUB_EN
        wd = 8'(a - b);
`else
        we = 1'b0;
`endif
      end
      default: wd = 8'(a);
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " rw"},   32'(bus.output_Read_Write), 32'd0);
    check({tag, " busy"}, 32'(bus.output_Busy), 32'd0);
    check({tag, " done"}, 32'(bus.output_Done), 32'd0);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of cycle 5 (idle)
  task automatic run_instr(input logic [7:0] ins, input bit poke, input string name);
    bit we;
    logic [1:0] wa;
    logic [7:0] wd;
    predict(ins, we, wa, wd);
    bus.input_Start       = 1'b1;
    bus.input_Instruction = ins;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.input_Start       = (poke && k <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.input_Instruction = 8'($urandom);
      case (k)
        1: begin
          check({name, " c1 busy"}, 32'(bus.output_Busy), 32'd1);
          check({name, " c1 rw"},   32'(bus.output_Read_Write), 32'd0);
          check({name, " c1 rs"},   32'(bus.output_Read_Register1), 32'(ins[5:4]));
          check({name, " c1 rt"},   32'(bus.output_Read_Register2), 32'(ins[3:2]));
        end
        2: begin
          check({name, " c2 busy"}, 32'(bus.output_Busy), 32'd1);
          check({name, " c2 rw"},   32'(bus.output_Read_Write), 32'd0);
        end
        3: begin
          check({name, " c3 busy"}, 32'(bus.output_Busy), 32'd1);
          check({name, " c3 done"}, 32'(bus.output_Done), 32'd0);
          check({name, " c3 rw"},   32'(bus.output_Read_Write), 32'(we));
          check({name, " c3 wdata"}, 32'(bus.output_Write_Data), 32'(wd));
          if (we) check({name, " c3 waddr"}, 32'(bus.output_Write_Register), 32'(wa));
        end
        4: begin
          check({name, " c4 done"}, 32'(bus.output_Done), 32'd1);
          check({name, " c4 busy"}, 32'(bus.output_Busy), 32'd0);
          check({name, " c4 rw"},   32'(bus.output_Read_Write), 32'd0);
          check({name, " c4 rs hold"}, 32'(bus.output_Read_Register1), 32'(ins[5:4]));
          if (we) begin
            ref_regs[wa] = wd;
            check({name, " rf write"}, 32'(rf[wa]), 32'(wd));
          end
        end
        default: check_idle_outputs({name, " c5"});
      endcase
    end
  endtask

  initial begin
    bit we;
    logic [1:0] wa;
    logic [7:0] wd;
    int rises[$];
    int dones[$];
    logic prev_busy;

    for (int i = 0; i < 4; i++) begin
      rf[i]       = 8'h00;
      ref_regs[i] = 8'h00;
    end
    bus.input_Start       = 1'b0;
    bus.input_Instruction = 8'h00;
    repeat (3) @(negedge clk);
    check("reset rw",    32'(bus.output_Read_Write), 32'd0);
    check("reset busy",  32'(bus.output_Busy), 32'd0);
    check("reset done",  32'(bus.output_Done), 32'd0);
    check("reset addrs", 32'({bus.output_Read_Register1, bus.output_Read_Register2,
                              bus.output_Write_Register}), 32'd0);
    check("reset wdata", 32'(bus.output_Write_Data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed sequence from the plan
    run_instr(8'h47, 1'b0, "addi");
    check("addi r1", 32'(rf[1]), 32'hFF);
    run_instr(8'h16, 1'b0, "add");
    check("add r2", 32'(rf[2]), 32'hFE);
    run_instr(8'hA7, 1'b0, "sub");
`ifdef REGSEQ_SUB_EN
    check("sub r3", 32'(rf[3]), 32'hFF);
`else
    check("nop r3", 32'(rf[3]), 32'h00);
`endif

    // Start held high for 10 cycles: two acceptances 5 cycles apart
    predict(8'hD0, we, wa, wd);
    bus.input_Start       = 1'b1;
    bus.input_Instruction = 8'hD0;
    prev_busy = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.output_Busy && !prev_busy) rises.push_back(c);
      if (bus.output_Done) dones.push_back(c);
      prev_busy = bus.output_Busy;
      if (c == 10) bus.input_Start = 1'b0;
    end
    check("held accepts", 32'(rises.size()), 32'd2);
    check("held dones",   32'(dones.size()), 32'd2);
    if (rises.size() == 2) check("held spacing", 32'(rises[1] - rises[0]), 32'd5);
    if (dones.size() == 2) check("held done pos", 32'(dones[0]), 32'd4);
    if (we) ref_regs[wa] = wd;
    check("mov r0", 32'(rf[0]), 32'hFF);

    // Reset during EXEC aborts the instruction without a write or done pulse
    bus.input_Start       = 1'b1;
    bus.input_Instruction = 8'h47;
    @(negedge clk);
    bus.input_Start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("abort");
    check("abort addrs", 32'({bus.output_Read_Register1, bus.output_Read_Register2,
                              bus.output_Write_Register}), 32'd0);
    check("abort wdata", 32'(bus.output_Write_Data), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle_outputs("post abort");
    end
    check("abort r1 kept", 32'(rf[1]), 32'(ref_regs[1]));

    // Random instructions with random idle gaps and ignored mid-flight start pulses
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr(8'($urandom), 1'b1, $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < 4; i++) check($sformatf("final r%0d", i), 32'(rf[i]), 32'(ref_regs[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
